// File: rtl/mgt_01_mul_unit_pkg.sv
// Shared types and constants for the iterative RV32M multiplier.
package mgt_01_mul_unit_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned MUL_ITER = XLEN + 1;

    typedef enum logic [1:0] {
        MUL_    = 2'd0,
        MULH_   = 2'd1,
        MULHSU_ = 2'd2,
        MULHU_  = 2'd3
    } mul_ops_e;

    typedef enum logic {
        FREE = 1'b0,
        BUSY = 1'b1
    } fu_state_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MULTIPLY = 2'd1,
        DONE     = 2'd2
    } mul_fsm_e;

endpackage

// File: rtl/mgt_01_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M, then arithmetic right shift.
module mgt_01_booth_step #(
    parameter int unsigned W = 32
) (
    input  logic [W+1:0] acc,
    input  logic [W:0]   q,
    input  logic         q_m1,
    input  logic [W:0]   m,
    output logic [W+1:0] acc_next,
    output logic [W:0]   q_next,
    output logic         q_m1_next
);

    logic [W+1:0] m_sext;
    logic [W+1:0] sum;

    assign m_sext = {m[W], m};

    always_comb begin
        sum = acc;
        case ({q[0], q_m1})
            2'b01:   sum = acc + m_sext;
            2'b10:   sum = acc - m_sext;
            default: sum = acc;
        endcase
    end

    assign acc_next  = {sum[W+1], sum[W+1:1]};
    assign q_next    = {sum[0], q[W:1]};
    assign q_m1_next = q[0];

endmodule

// File: rtl/mgt_01_mul_unit.sv
// Iterative Booth multiplier for MUL/MULH/MULHSU/MULHU; one result per accepted op.
module mgt_01_mul_unit
    import mgt_01_mul_unit_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            clk_en_i,
    input  logic            valid_i,
    input  logic [XLEN-1:0] multiplicand_i,
    input  logic [XLEN-1:0] multiplier_i,
    input  mul_ops_e        operation_i,
    output logic [XLEN-1:0] result_o,
    output logic            valid_o,
    output fu_state_e       fu_state_o
);

    localparam logic [5:0] LAST_ITER = 6'(MUL_ITER - 1);

    mul_fsm_e        state;
    mul_ops_e        op_q;
    logic [5:0]      cnt;
    logic [XLEN+1:0] acc;
    logic [XLEN:0]   q;
    logic [XLEN:0]   m;
    logic            q_m1;

    logic [XLEN+1:0]   acc_nxt;
    logic [XLEN:0]     q_nxt;
    logic              q_m1_nxt;
    logic [XLEN:0]     mcand_ext;
    logic [XLEN:0]     mplier_ext;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   result_sel;

    // MUL_ sign-extends both operands; only the low word is kept, so either extension works.
    assign mcand_ext  = {(operation_i != MULHU_) & multiplicand_i[XLEN-1], multiplicand_i};
    assign mplier_ext = {((operation_i == MUL_) || (operation_i == MULH_)) & multiplier_i[XLEN-1],
                         multiplier_i};

    mgt_01_booth_step #(.W(XLEN)) u_booth_step (
        .acc       (acc),
        .q         (q),
        .q_m1      (q_m1),
        .m         (m),
        .acc_next  (acc_nxt),
        .q_next    (q_nxt),
        .q_m1_next (q_m1_nxt)
    );

    // The 2*XLEN product sits in the low bits of {A, Q} after the final shift.
    assign prod       = {acc_nxt[XLEN-2:0], q_nxt};
    assign result_sel = (op_q == MUL_) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            op_q       <= MUL_;
            cnt        <= '0;
            acc        <= '0;
            q          <= '0;
            m          <= '0;
            q_m1       <= 1'b0;
            result_o   <= '0;
            valid_o    <= 1'b0;
            fu_state_o <= FREE;
        end else if (clk_en_i) begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        state      <= MULTIPLY;
                        fu_state_o <= BUSY;
                        op_q       <= operation_i;
                        m          <= mcand_ext;
                        q          <= mplier_ext;
                        acc        <= '0;
                        q_m1       <= 1'b0;
                        cnt        <= '0;
                    end
                end
                MULTIPLY: begin
                    acc  <= acc_nxt;
                    q    <= q_nxt;
                    q_m1 <= q_m1_nxt;
                    cnt  <= cnt + 6'd1;
                    if (cnt == LAST_ITER) begin
                        state    <= DONE;
                        result_o <= result_sel;
                        valid_o  <= 1'b1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    valid_o    <= 1'b0;
                    fu_state_o <= FREE;
                end
                default: begin
                    state      <= IDLE;
                    valid_o    <= 1'b0;
                    fu_state_o <= FREE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mgt_01_mul_unit.sv
// Self-checking bench for mgt_01_mul_unit: directed cases plus randomized ops vs. an arithmetic model.
module tb_mgt_01_mul_unit;
    import mgt_01_mul_unit_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        clk_en_i;
    logic        valid_i;
    logic [31:0] multiplicand_i;
    logic [31:0] multiplier_i;
    mul_ops_e    operation_i;
    logic [31:0] result_o;
    logic        valid_o;
    fu_state_e   fu_state_o;

    int n_checks = 0;
    int n_fail   = 0;

    mgt_01_mul_unit dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .clk_en_i       (clk_en_i),
        .valid_i        (valid_i),
        .multiplicand_i (multiplicand_i),
        .multiplier_i   (multiplier_i),
        .operation_i    (operation_i),
        .result_o       (result_o),
        .valid_o        (valid_o),
        .fu_state_o     (fu_state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input mul_ops_e op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (op == MULHU_) ? {32'h0, a} : {{32{a[31]}}, a};
        eb = (op == MUL_ || op == MULH_) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        return (op == MUL_) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic no_valid_for(input string tag, input int n);
        bit seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            if (valid_o) seen = 1;
        end
        check_eq(tag, 32'(seen), 32'd0);
    endtask

    // Issues one op and follows it to completion; optional stall window, stray valid pulses,
    // and a post-result hold with clock enable low.
    task automatic run_op(input mul_ops_e op, input logic [31:0] a, input logic [31:0] b,
                          input int stall_at, input int stall_len,
                          input bit pulse_mid, input bit pulse_done, input bit hold_after,
                          output logic [31:0] res);
        logic [31:0] exp;
        int  c, en_cnt;
        bit  seen, busy_ok;
        exp = ref_mul(op, a, b);
        @(negedge clk_i);
        clk_en_i       = 1'b1;
        valid_i        = 1'b1;
        operation_i    = op;
        multiplicand_i = a;
        multiplier_i   = b;
        @(negedge clk_i);
        valid_i        = 1'b0;
        multiplicand_i = $urandom;
        multiplier_i   = $urandom;
        operation_i    = mul_ops_e'($urandom_range(0, 3));
        c = 0; en_cnt = 0; seen = 0; busy_ok = (fu_state_o == BUSY);
        while (!seen && c < 200) begin
            clk_en_i = !(stall_len > 0 && c >= stall_at && c < stall_at + stall_len);
            if (pulse_mid && c == 5) begin
                valid_i        = 1'b1;
                multiplicand_i = a ^ 32'h0F0F_1234;
                operation_i    = (op == MUL_) ? MULHU_ : MUL_;
            end else begin
                valid_i = 1'b0;
            end
            @(posedge clk_i);
            c++;
            if (clk_en_i) en_cnt++;
            @(negedge clk_i);
            if (valid_o) seen = 1;
            else if (fu_state_o != BUSY) busy_ok = 0;
        end
        valid_i  = 1'b0;
        clk_en_i = 1'b1;
        res      = result_o;
        check_eq("valid_seen", 32'(seen), 32'd1);
        check_eq("busy_during_op", 32'(busy_ok), 32'd1);
        check_eq("latency_enabled", 32'(en_cnt), 32'd33);
        check_eq("latency_clocks", 32'(c), 32'(33 + stall_len));
        check_eq("result", result_o, exp);
        if (hold_after) begin
            clk_en_i = 1'b0;
            repeat (3) @(negedge clk_i);
            check_eq("valid_held_disabled", 32'(valid_o), 32'd1);
            check_eq("result_held_disabled", result_o, exp);
            clk_en_i = 1'b1;
        end
        if (pulse_done) begin
            valid_i        = 1'b1;
            multiplicand_i = ~a;
            multiplier_i   = b + 32'd3;
        end
        @(negedge clk_i);
        valid_i = 1'b0;
        check_eq("valid_one_cycle", 32'(valid_o), 32'd0);
        check_eq("free_after_done", 32'(fu_state_o), 32'(FREE));
        check_eq("result_held", result_o, exp);
    endtask

    initial begin
        logic [31:0] r;
        mul_ops_e    op;
        rst_n_i        = 1'b0;
        clk_en_i       = 1'b1;
        valid_i        = 1'b0;
        multiplicand_i = '0;
        multiplier_i   = '0;
        operation_i    = MUL_;
        #12;
        check_eq("reset_result", result_o, 32'h0);
        check_eq("reset_valid", 32'(valid_o), 32'd0);
        check_eq("reset_fu_state", 32'(fu_state_o), 32'(FREE));
        @(negedge clk_i);
        rst_n_i = 1'b1;

        run_op(MUL_, 32'd7, 32'd6, 0, 0, 0, 0, 0, r);
        check_eq("mul_7x6", r, 32'h0000_002A);
        run_op(MULH_, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, 0, 0, r);
        check_eq("mulh_minneg", r, 32'h4000_0000);
        run_op(MUL_, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, 0, 0, r);
        check_eq("mul_minneg", r, 32'h0000_0000);
        run_op(MULH_, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, r);
        check_eq("mulh_ones", r, 32'h0000_0000);
        run_op(MULHSU_, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, r);
        check_eq("mulhsu_ones", r, 32'hFFFF_FFFF);
        run_op(MULHU_, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, r);
        check_eq("mulhu_ones", r, 32'hFFFF_FFFE);
        run_op(MUL_, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, r);
        check_eq("mul_ones", r, 32'h0000_0001);

        run_op(MULHU_, 32'h1234_5678, 32'h9ABC_DEF0, 12, 10, 0, 0, 1, r);
        check_eq("mulhu_stalled", r, 32'h0B00_EA4E);

        run_op(MULH_, 32'h1357_9BDF, 32'hFEDC_BA98, 0, 0, 1, 1, 0, r);
        check_eq("ignore_valid_busy", r, ref_mul(MULH_, 32'h1357_9BDF, 32'hFEDC_BA98));
        no_valid_for("no_queued_op", 40);

        // Abort mid-operation with reset.
        @(negedge clk_i);
        valid_i        = 1'b1;
        operation_i    = MULHU_;
        multiplicand_i = 32'hDEAD_BEEF;
        multiplier_i   = 32'hCAFE_F00D;
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (15) @(negedge clk_i);
        rst_n_i = 1'b0;
        #1;
        check_eq("abort_result", result_o, 32'h0);
        check_eq("abort_valid", 32'(valid_o), 32'd0);
        check_eq("abort_fu_state", 32'(fu_state_o), 32'(FREE));
        @(negedge clk_i);
        rst_n_i = 1'b1;
        no_valid_for("abort_no_valid", 40);
        run_op(MUL_, 32'hFFFF_FFFD, 32'd5, 0, 0, 0, 0, 0, r);
        check_eq("mul_m3x5", r, 32'hFFFF_FFF1);

        for (int i = 0; i < 30; i++) begin
            op = mul_ops_e'($urandom_range(0, 3));
            run_op(op, pick_operand(), pick_operand(),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 25)) : 0,
                   int'($urandom_range(0, 4)), 0, 0, 0, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
